board_controller: RTL and testbench
===================================

Name: board_controller

Overview:
- Game-state engine for the Connect-4 display. It holds board occupancy, the per-column fill heights, the cursor column and the current player.
- It accepts debounced button pulses and animates a falling piece row by row.
- It produces the green_grid/blue_grid frame consumed directly by the LED matrix row-scan driver.
- Player 0 is green; player 1 is blue.

Parameters:
- STEP_CYCLES, 5000000, clock cycles each falling-piece row is displayed (>=1).
- NUM_ROWS, 6, playable rows (rows 0..NUM_ROWS-1, row 0 = bottom); fixed <=6.
- NUM_COLS, 7, playable columns (bits 0..NUM_COLS-1); fixed <=8.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_left  input  1  one-cycle pulse: move cursor left.
- btn_right  input  1  one-cycle pulse: move cursor right.
- btn_drop  input  1  one-cycle pulse: drop piece in cursor column.
- game_over_in  input  1  level from external win checker; freezes play.
- green_grid  output  [7:0][7:0]  frame, green_grid[r] = row r byte, bit c = column c.
- blue_grid  output  [7:0][7:0]  same layout, blue pieces.
- current_player  output  1  0 = green to move, 1 = blue to move.
- busy  output  1  high while a piece is falling.
- drop_done  output  1  one-cycle pulse when a piece lands.
- drop_reject  output  1  one-cycle pulse when a drop hits a full column.
- board_full  output  1  high once all NUM_ROWS*NUM_COLS cells are occupied.

Behaviour:
- All outputs registered. Synchronous reset (priority over everything, including mid-fall):
  - board empty, heights 0, cursor column 0, current_player 0;
  - fall counter 0, state IDLE;
  - all pulse and flag outputs 0.
- Frame composition, updated the cycle after any state change:
  - Rows 0..NUM_ROWS-1: occupancy in owner colour.
  - Row 7: in IDLE only, a single cursor bit at cursor column, in current_player colour.
  - Falling piece: shown at (fall_row, drop column) in current_player colour.
  - Unused rows and columns always 0. Green and blue never both set on the same cell.
- FSM states:
  - IDLE:
    - Priority: game_over_in -> DONE; else btn_drop; else a left/right move.
    - btn_drop, height[cursor] < NUM_ROWS: latch drop column = cursor; fall_row = NUM_ROWS (row 6); counter = 0; state FALL; busy = 1.
    - btn_drop, height[cursor] == NUM_ROWS: drop_reject pulses next cycle; stay in IDLE; player unchanged.
    - btn_left and btn_right together: ignored.
    - Left at column 0 and right at NUM_COLS-1 saturate (no wrap).
    - Drop takes priority over a same-cycle move; the move is discarded.
  - FALL:
    - Counter increments each cycle. At count == STEP_CYCLES-1 the counter clears, then:
      - if fall_row == height[col], LAND;
      - else fall_row decrements.
    - Effect: a drop into an empty column displays rows 6,5,...,0 for STEP_CYCLES cycles each.
    - All buttons ignored (not queued). game_over_in ignored until the landing completes.
  - LAND (single cycle):
    - Write the cell at (height[col], col) for current_player; height[col] += 1; piece count += 1.
    - Toggle current_player. Pulse drop_done. busy = 0.
    - Next state is FULL if piece count == NUM_ROWS*NUM_COLS, else IDLE.
    - drop_done is coincident with the first frame showing the landed piece.
  - FULL: board_full = 1; cursor hidden; all inputs ignored until reset.
  - DONE: cursor hidden; board frozen; leaves only on reset (game_over_in falling does not resume).
- Widths:
  - Heights 3 bits each. Piece count 6 bits. fall_row 3 bits.
  - Fall counter sized $clog2(STEP_CYCLES)+1 bits.

Test Plan:
- Reset, then btn_drop (STEP_CYCLES=2) -> busy the next cycle; green piece at column 0 walks rows 6..0 for 2 cycles each; drop_done pulses; green_grid[0]=8'h01; current_player=1; cursor appears in blue_grid[7]=8'h01.
- btn_right x3, btn_left x1, then btn_left x5 -> cursor column 2, then 0 (saturates); btn_left+btn_right in the same cycle -> no movement.
- Six drops into column 3 alternating players, then a seventh -> rows 0..5 alternate green/blue at bit 3; the seventh drop pulses drop_reject; current_player unchanged; busy stays 0.
- Button pulses during FALL -> ignored; cursor column unchanged after landing. Reset asserted mid-fall -> next cycle all grids 0 except green_grid[7]=8'h01; busy=0.
- Fill all 42 cells -> board_full=1 after the last drop_done; row 7 = 0; further drops have no effect.
- game_over_in=1 in IDLE -> DONE; cursor cleared; btn_drop ignored; frame stays frozen after game_over_in drops.

Source files
------------

// File: rtl/board_controller.sv
// Connect-4 game-state engine: board occupancy, column heights, cursor, player
// turn and falling-piece animation, composed into the LED matrix frame.
module board_controller #(
    parameter int unsigned STEP_CYCLES = 5000000,
    parameter int unsigned NUM_ROWS    = 6,
    parameter int unsigned NUM_COLS    = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_drop,
    input  logic            game_over_in,
    output logic [7:0][7:0] green_grid,
    output logic [7:0][7:0] blue_grid,
    output logic            current_player,
    output logic            busy,
    output logic            drop_done,
    output logic            drop_reject,
    output logic            board_full
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES) + 1;
    localparam int unsigned CELLS = NUM_ROWS * NUM_COLS;

    typedef enum logic [2:0] {IDLE, FALL, LAND, FULL, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0][7:0]  occ_g_q, occ_g_d, occ_b_q, occ_b_d;
    logic [7:0][2:0]  height_q, height_d;
    logic [2:0]       cursor_q, cursor_d, col_q, col_d, row_q, row_d;
    logic             player_q, player_d;
    logic [5:0]       pieces_q, pieces_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0][7:0]  green_d, blue_d;
    logic             reject_d;

    // State and output registers; outputs reflect the post-edge game state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            occ_g_q        <= '0;
            occ_b_q        <= '0;
            height_q       <= '0;
            cursor_q       <= '0;
            col_q          <= '0;
            row_q          <= '0;
            player_q       <= 1'b0;
            pieces_q       <= '0;
            cnt_q          <= '0;
            green_grid     <= 64'h0100_0000_0000_0000;
            blue_grid      <= '0;
            current_player <= 1'b0;
            busy           <= 1'b0;
            drop_done      <= 1'b0;
            drop_reject    <= 1'b0;
            board_full     <= 1'b0;
        end else begin
            state_q        <= state_d;
            occ_g_q        <= occ_g_d;
            occ_b_q        <= occ_b_d;
            height_q       <= height_d;
            cursor_q       <= cursor_d;
            col_q          <= col_d;
            row_q          <= row_d;
            player_q       <= player_d;
            pieces_q       <= pieces_d;
            cnt_q          <= cnt_d;
            green_grid     <= green_d;
            blue_grid      <= blue_d;
            current_player <= player_d;
            busy           <= (state_d == FALL);
            drop_done      <= (state_q == LAND);
            drop_reject    <= reject_d;
            board_full     <= (state_d == FULL);
        end
    end

    // Next-state logic for the game engine.
    always_comb begin
        state_d  = state_q;
        occ_g_d  = occ_g_q;
        occ_b_d  = occ_b_q;
        height_d = height_q;
        cursor_d = cursor_q;
        col_d    = col_q;
        row_d    = row_q;
        player_d = player_q;
        pieces_d = pieces_q;
        cnt_d    = cnt_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (game_over_in) begin
                    state_d = DONE;
                end else if (btn_drop) begin
                    if (height_q[cursor_q] < 3'(NUM_ROWS)) begin
                        col_d   = cursor_q;
                        row_d   = 3'(NUM_ROWS);
                        cnt_d   = '0;
                        state_d = FALL;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (btn_left && !btn_right && cursor_q != 3'd0) begin
                    cursor_d = cursor_q - 3'd1;
                end else if (btn_right && !btn_left && cursor_q != 3'(NUM_COLS - 1)) begin
                    cursor_d = cursor_q + 3'd1;
                end
            end
            FALL: begin
                if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (row_q == height_q[col_q]) begin
                        state_d = LAND;
                    end else begin
                        row_d = row_q - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LAND: begin
                if (player_q) begin
                    occ_b_d[height_q[col_q]][col_q] = 1'b1;
                end else begin
                    occ_g_d[height_q[col_q]][col_q] = 1'b1;
                end
                height_d[col_q] = height_q[col_q] + 3'd1;
                pieces_d        = pieces_q + 6'd1;
                player_d        = ~player_q;
                state_d         = (pieces_d == 6'(CELLS)) ? FULL : IDLE;
            end
            FULL: state_d = FULL;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Frame: occupancy, plus the falling piece (kept visible through LAND) or the cursor.
    always_comb begin
        green_d = occ_g_d;
        blue_d  = occ_b_d;
        if (state_d == FALL || state_d == LAND) begin
            if (player_d) begin
                blue_d[row_d][col_d] = 1'b1;
            end else begin
                green_d[row_d][col_d] = 1'b1;
            end
        end
        if (state_d == IDLE) begin
            if (player_d) begin
                blue_d[7][cursor_d] = 1'b1;
            end else begin
                green_d[7][cursor_d] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_controller.sv
// Self-checking bench for board_controller: vector table for cursor moves,
// scoreboard queue of per-cycle expectations, hand sequences for drops.
module tb_board_controller;

    localparam int unsigned STEP = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            btn_left = 1'b0;
    logic            btn_right = 1'b0;
    logic            btn_drop = 1'b0;
    logic            game_over_in = 1'b0;
    logic [7:0][7:0] green_grid;
    logic [7:0][7:0] blue_grid;
    logic            current_player;
    logic            busy;
    logic            drop_done;
    logic            drop_reject;
    logic            board_full;

    board_controller #(.STEP_CYCLES(STEP), .NUM_ROWS(6), .NUM_COLS(7)) dut (
        .clock          (clock),
        .reset          (reset),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_drop       (btn_drop),
        .game_over_in   (game_over_in),
        .green_grid     (green_grid),
        .blue_grid      (blue_grid),
        .current_player (current_player),
        .busy           (busy),
        .drop_done      (drop_done),
        .drop_reject    (drop_reject),
        .board_full     (board_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] g7;
        logic [7:0] b7;
        logic       player;
        logic       bsy;
        logic       done;
        logic       rej;
        logic       full;
    } exp_t;

    typedef struct {
        logic       l;
        logic       r;
        logic [2:0] col;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   tests = 0;
    int   fails = 0;
    logic [7:0][7:0] eg, eb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void want(input logic [7:0] g7, input logic [7:0] b7, input logic p,
                                 input logic bz, input logic dn, input logic rj, input logic fl);
        exp_t e;
        e = '{g7, b7, p, bz, dn, rj, fl};
        sb.push_back(e);
    endfunction

    // One clock: drive on negedge, sample 1ns after posedge, score any queued expectation.
    task automatic tick(input logic l, input logic r, input logic d);
        exp_t e;
        @(negedge clock);
        btn_left  = l;
        btn_right = r;
        btn_drop  = d;
        @(posedge clock);
        #1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_green_row7", 64'(green_grid[7]), 64'(e.g7));
            chk("sb_blue_row7", 64'(blue_grid[7]), 64'(e.b7));
            chk("sb_player", 64'(current_player), 64'(e.player));
            chk("sb_busy", 64'(busy), 64'(e.bsy));
            chk("sb_drop_done", 64'(drop_done), 64'(e.done));
            chk("sb_drop_reject", 64'(drop_reject), 64'(e.rej));
            chk("sb_board_full", 64'(board_full), 64'(e.full));
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (drop_done) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: drop_done not seen within 100 cycles (got 0 expected 1)", name);
        end
    endtask

    task automatic drop_wait(input string name);
        tick(1'b0, 1'b0, 1'b1);
        wait_done(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got timeout expected finish)");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back('{1'b0, 1'b1, 3'd1});
        vt.push_back('{1'b0, 1'b1, 3'd2});
        vt.push_back('{1'b0, 1'b1, 3'd3});
        vt.push_back('{1'b1, 1'b0, 3'd2});
        for (int i = 0; i < 5; i++) vt.push_back('{1'b1, 1'b0, 3'(i < 2 ? 1 - i : 0)});
        vt.push_back('{1'b1, 1'b1, 3'd0});
        for (int i = 1; i <= 7; i++) vt.push_back('{1'b0, 1'b1, 3'(i > 6 ? 6 : i)});
        vt.push_back('{1'b1, 1'b1, 3'd6});
        vt.push_back('{1'b1, 1'b0, 3'd5});
        vt.push_back('{1'b1, 1'b0, 3'd4});
        vt.push_back('{1'b1, 1'b0, 3'd3});

        // Reset state.
        want(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("reset_green", green_grid, 64'h0100_0000_0000_0000);
        chk("reset_blue", blue_grid, 64'h0);
        reset = 1'b0;
        want(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // First drop: green piece walks rows 6..0 in column 0.
        want(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        for (int r = 6; r >= 0; r--) begin
            for (int k = 0; k < int'(STEP); k++) begin
                chk("fall_green", green_grid, 64'(1) << (8 * r));
                chk("fall_busy", 64'(busy), 64'd1);
                tick(1'b0, 1'b0, 1'b0);
            end
        end
        chk("land_busy", 64'(busy), 64'd0);
        chk("land_green", green_grid, 64'h01);
        chk("land_done_early", 64'(drop_done), 64'd0);
        want(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("landed_green", green_grid, 64'h01);
        want(8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // Cursor movement table (blue to move).
        for (int i = 0; i < vt.size(); i++) begin
            want(8'h00, 8'(1) << vt[i].col, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(vt[i].l, vt[i].r, 1'b0);
        end

        // Fill column 3 alternately, then reject the seventh drop.
        for (int i = 0; i < 6; i++) drop_wait("col3_land");
        for (int r = 0; r < 6; r++) begin
            chk("col3_green", 64'(green_grid[r][3]), 64'(r % 2));
            chk("col3_blue", 64'(blue_grid[r][3]), 64'(1 - r % 2));
        end
        want(8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        want(8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // Buttons during a fall are ignored.
        want(8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        wait_done("ignore_land");
        chk("ignore_cursor", 64'(green_grid[7]), 64'h04);
        chk("ignore_blue_row0", 64'(blue_grid[0]), 64'h0C);
        tick(1'b0, 1'b0, 1'b0);
        chk("ignore_busy", 64'(busy), 64'd0);

        // Reset during a fall.
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        want(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("midfall_reset_green", green_grid, 64'h0100_0000_0000_0000);
        chk("midfall_reset_blue", blue_grid, 64'h0);
        reset = 1'b0;

        // Fill all 42 cells column by column.
        eg = '0;
        eb = '0;
        for (int k = 0; k < 42; k++) begin
            if (k % 2 == 0) eg[k % 6][k / 6] = 1'b1;
            else            eb[k % 6][k / 6] = 1'b1;
        end
        for (int c = 0; c < 7; c++) begin
            for (int j = 0; j < 6; j++) begin
                if (c == 6 && j == 5) chk("full_before_last", 64'(board_full), 64'd0);
                drop_wait("fill_land");
            end
            if (c < 6) tick(1'b0, 1'b1, 1'b0);
        end
        chk("full_at_last_done", 64'(board_full), 64'd1);
        tick(1'b0, 1'b0, 1'b0);
        chk("full_green", green_grid, eg);
        chk("full_blue", blue_grid, eb);
        want(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        want(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1);
        chk("full_frozen_green", green_grid, eg);
        chk("full_frozen_blue", blue_grid, eb);

        // Game over freezes the board permanently.
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drop_wait("go_land");
        game_over_in = 1'b1;
        want(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        want(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        game_over_in = 1'b0;
        want(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        want(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        chk("done_frozen_green", green_grid, 64'h01);
        chk("done_frozen_blue", blue_grid, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
